// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-requester RAM write arbiter.
// Holds the FSM encoding, grant index type, write payload and result-count helper.
package ram_arb_pkg;

  localparam int unsigned STATE_W = 2;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 8;

  localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] ST_RUN  = 2'd1;
  localparam logic [STATE_W-1:0] ST_FIN  = 2'd2;

  typedef logic gidx_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } ram_wr_t;

  // Results per requester: each result covers a 2x2 window of the feature map.
  function automatic int unsigned calc_n(input int unsigned h, input int unsigned w);
    return (h * w) / 4;
  endfunction

endpackage

// File: rtl/ram_wr_arbiter_if.sv
// Requester handshake and RAM write port bundle for ram_wr_arbiter.
interface ram_wr_arbiter_if;
  import ram_arb_pkg::*;

  logic              start;
  logic [DATA_W-1:0] ans0;
  logic [DATA_W-1:0] ans1;
  logic              valid0;
  logic              valid1;
  logic              ready0;
  logic              ready1;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wr;
  logic              done0;
  logic              done1;
  logic              intr;

  modport slave (
    input  start, ans0, ans1, valid0, valid1,
    output ready0, ready1, ram_en, ram_we, ram_addr, ram_wr, done0, done1, intr
  );

  modport master (
    output start, ans0, ans1, valid0, valid1,
    input  ready0, ready1, ram_en, ram_we, ram_addr, ram_wr, done0, done1, intr
  );

endinterface

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin picker: a lone eligible requester wins,
// a tie goes to the requester that was not granted last.
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic [1:0] elig,
  input  gidx_t      last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (elig)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last == 1'b0) ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/ram_wr_arbiter.sv
// Merges result streams from two requesters into single-port RAM writes,
// one write per cycle, round-robin on contention, with per-frame completion flags.
module ram_wr_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned       H     = 6,
  parameter int unsigned       W     = 6,
  parameter logic [ADDR_W-1:0] BASE0 = 32'd0,
  parameter logic [ADDR_W-1:0] BASE1 = 32'd64
) (
  input  logic              clk,
  input  logic              rst,
  ram_wr_arbiter_if.slave   bus
);

  localparam int unsigned      N     = calc_n(H, W);
  localparam logic [CNT_W-1:0] N_CNT = CNT_W'(N);

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_nxt;

  logic [CNT_W-1:0]   cnt0;
  logic [CNT_W-1:0]   cnt1;
  logic [CNT_W-1:0]   cnt0_nxt;
  logic [CNT_W-1:0]   cnt1_nxt;
  gidx_t              last;
  gidx_t              last_eff;

  logic [1:0]         elig;
  logic [1:0]         grant;
  logic               xfer0;
  logic               xfer1;
  logic               start_ok;
  ram_wr_t            wr_c;

  logic               ram_en_q;
  logic [ADDR_W-1:0]  ram_addr_q;
  logic [DATA_W-1:0]  ram_wr_q;
  logic               done0_q;
  logic               done1_q;
  logic               intr_q;

  assign start_ok = (state == ST_IDLE) && bus.start;

  assign elig[0] = (state == ST_RUN) && bus.valid0 && (cnt0 < N_CNT);
  assign elig[1] = (state == ST_RUN) && bus.valid1 && (cnt1 < N_CNT);

  // Until the first grant of a frame, requester 0 leads on a tie.
  assign last_eff = ((cnt0 == '0) && (cnt1 == '0)) ? 1'b1 : last;

  rr_arb2 u_rr_arb2 (
    .elig  (elig),
    .last  (last_eff),
    .grant (grant)
  );

  assign bus.ready0 = grant[0] && !rst;
  assign bus.ready1 = grant[1] && !rst;

  assign xfer0 = bus.valid0 && bus.ready0;
  assign xfer1 = bus.valid1 && bus.ready1;

  assign cnt0_nxt = cnt0 + CNT_W'(xfer0);
  assign cnt1_nxt = cnt1 + CNT_W'(xfer1);

  // Address and data for whichever requester transfers this cycle.
  always_comb begin
    wr_c.addr = BASE0 + ADDR_W'(cnt0);
    wr_c.data = bus.ans0;
    if (xfer1) begin
      wr_c.addr = BASE1 + ADDR_W'(cnt1);
      wr_c.data = bus.ans1;
    end
  end

  // Frame sequencing.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (bus.start) state_nxt = ST_RUN;
      ST_RUN:  if ((cnt0_nxt == N_CNT) && (cnt1_nxt == N_CNT)) state_nxt = ST_FIN;
      ST_FIN:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Counters, round-robin history, completion flags and the registered RAM port.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0       <= '0;
      cnt1       <= '0;
      last       <= 1'b0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      intr_q     <= 1'b0;
      ram_en_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_wr_q   <= '0;
    end else begin
      ram_en_q <= xfer0 || xfer1;
      intr_q   <= (state_nxt == ST_FIN);
      if (start_ok) begin
        cnt0    <= '0;
        cnt1    <= '0;
        last    <= 1'b0;
        done0_q <= 1'b0;
        done1_q <= 1'b0;
      end else begin
        if (xfer0) begin
          cnt0 <= cnt0_nxt;
          last <= 1'b0;
          if (cnt0_nxt == N_CNT) done0_q <= 1'b1;
        end
        if (xfer1) begin
          cnt1 <= cnt1_nxt;
          last <= 1'b1;
          if (cnt1_nxt == N_CNT) done1_q <= 1'b1;
        end
      end
      if (xfer0 || xfer1) begin
        ram_addr_q <= wr_c.addr;
        ram_wr_q   <= wr_c.data;
      end
    end
  end

  assign bus.ram_en   = ram_en_q;
  assign bus.ram_we   = ram_en_q;
  assign bus.ram_addr = ram_addr_q;
  assign bus.ram_wr   = ram_wr_q;
  assign bus.done0    = done0_q;
  assign bus.done1    = done1_q;
  assign bus.intr     = intr_q;

endmodule
